iicmb_wb_regs: RTL and testbench

IICMB_WB_REGS -- requirements
Module: iicmb_wb_regs

---
 rtl/iicmb_wb_regs.sv | 217 +++++++++++++++++++++
 tb/tb_iicmb_wb_regs.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iicmb_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : iicmb_wb_regs
// Description : Wishbone register front-end of the I2C master: CSR/DPR/CMDR/
//               FSMR map, command hand-off to the byte FSM, status and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module iicmb_wb_regs #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  irq,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_code_o,
    output logic [7:0]            cmd_data_o,
    input  logic                  rsp_valid_i,
    input  logic [1:0]            rsp_code_i,
    input  logic [7:0]            rsp_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_captured_i,
    input  logic [3:0]            bus_id_i,
    input  logic [7:0]            fsm_state_i
);

    localparam int c_ADR_CSR  = 0;
    localparam int c_ADR_DPR  = 1;
    localparam int c_ADR_CMDR = 2;
    localparam int c_ADR_FSMR = 3;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_ISSUE    = 2'd1;
    localparam logic [1:0] c_WAIT_RSP = 2'd2;

    localparam logic [2:0] c_CMD_READ_ACK = 3'd3;
    localparam logic [2:0] c_CMD_READ_NAK = 3'd4;
    localparam logic [2:0] c_CMD_INVALID  = 3'd7;

    logic [1:0]            r_state;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_e;
    logic                  r_ie;
    logic                  r_irq;
    logic [7:0]            r_tx;
    logic [7:0]            r_rx;
    logic                  r_don;
    logic                  r_nak;
    logic                  r_al;
    logic                  r_err;
    logic [2:0]            r_last_cmd;

    logic       w_acc;
    logic       w_wr;
    logic       w_rd;
    logic       w_sel_csr;
    logic       w_sel_dpr;
    logic       w_sel_cmdr;
    logic       w_sel_fsmr;
    logic [7:0] w_wr_byte;
    logic       w_disable;
    logic       w_ie_off;
    logic       w_cmd_wr;
    logic       w_cmd_issue;
    logic       w_cmd_bad;
    logic       w_rsp;
    logic       w_status_set;
    logic       w_cmdr_rd;
    logic       w_issue;
    logic [7:0] w_rd_byte;

    // A new access is taken only when no ack is outstanding, so a held
    // strobe is acknowledged on alternate cycles.
    assign w_acc      = cyc_i & stb_i & ~r_ack;
    assign w_wr       = w_acc & we_i;
    assign w_rd       = w_acc & ~we_i;
    assign w_sel_csr  = (adr_i == ADDR_WIDTH'(c_ADR_CSR));
    assign w_sel_dpr  = (adr_i == ADDR_WIDTH'(c_ADR_DPR));
    assign w_sel_cmdr = (adr_i == ADDR_WIDTH'(c_ADR_CMDR));
    assign w_sel_fsmr = (adr_i == ADDR_WIDTH'(c_ADR_FSMR));
    assign w_wr_byte  = 8'(dat_i);

    assign w_disable    = w_wr & w_sel_csr & ~w_wr_byte[7];
    assign w_ie_off     = w_wr & w_sel_csr & ~w_wr_byte[6];
    assign w_cmd_wr     = w_wr & w_sel_cmdr & r_e & (r_state == c_IDLE);
    assign w_cmd_issue  = w_cmd_wr & (w_wr_byte[2:0] != c_CMD_INVALID);
    assign w_cmd_bad    = w_cmd_wr & (w_wr_byte[2:0] == c_CMD_INVALID);
    // Disabling the core in the same cycle as a response discards the response.
    assign w_rsp        = (r_state == c_WAIT_RSP) & rsp_valid_i & ~w_disable;
    assign w_status_set = w_rsp | w_cmd_bad;
    assign w_cmdr_rd    = w_rd & w_sel_cmdr;
    assign w_issue      = (r_state == c_ISSUE);

    always_comb begin
        w_rd_byte = 8'h00;
        if (w_sel_csr) begin
            w_rd_byte = {r_e, r_ie, bus_busy_i, bus_captured_i, bus_id_i};
        end else if (w_sel_dpr) begin
            w_rd_byte = r_rx;
        end else if (w_sel_cmdr) begin
            w_rd_byte = {r_don, r_nak, r_al, r_err, 1'b0, r_last_cmd};
        end else if (w_sel_fsmr) begin
            w_rd_byte = fsm_state_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? DATA_WIDTH'(w_rd_byte) : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_e  <= 1'b0;
            r_ie <= 1'b0;
            r_tx <= 8'h00;
        end else if (w_wr) begin
            if (w_sel_csr) begin
                r_e  <= w_wr_byte[7];
                r_ie <= w_wr_byte[6];
            end
            if (w_sel_dpr) begin
                r_tx <= w_wr_byte;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else if (w_disable) begin
            r_state <= c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_cmd_issue) begin
                        r_state <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (cmd_ready_i) begin
                        r_state <= c_WAIT_RSP;
                    end
                end
                c_WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_don      <= 1'b1;
            r_nak      <= 1'b0;
            r_al       <= 1'b0;
            r_err      <= 1'b0;
            r_last_cmd <= 3'd0;
            r_rx       <= 8'h00;
        end else if (w_cmd_issue) begin
            {r_don, r_nak, r_al, r_err} <= 4'b0000;
            r_last_cmd                  <= w_wr_byte[2:0];
        end else if (w_cmd_bad) begin
            {r_don, r_nak, r_al, r_err} <= 4'b0001;
            r_last_cmd                  <= c_CMD_INVALID;
        end else if (w_rsp) begin
            case (rsp_code_i)
                2'd0:    r_don <= 1'b1;
                2'd1:    r_nak <= 1'b1;
                2'd2:    r_al  <= 1'b1;
                default: r_err <= 1'b1;
            endcase
            if ((r_last_cmd == c_CMD_READ_ACK) || (r_last_cmd == c_CMD_READ_NAK)) begin
                r_rx <= rsp_data_i;
            end
        end
    end

    // A status set in the same cycle as a CMDR read keeps irq asserted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irq <= 1'b0;
        end else if (w_ie_off) begin
            r_irq <= 1'b0;
        end else if (w_status_set && r_ie) begin
            r_irq <= 1'b1;
        end else if (w_cmdr_rd) begin
            r_irq <= 1'b0;
        end
    end

    assign ack_o       = r_ack;
    assign dat_o       = r_dat;
    assign irq         = r_irq;
    assign cmd_valid_o = w_issue;
    assign cmd_code_o  = w_issue ? r_last_cmd : 3'd0;
    assign cmd_data_o  = w_issue ? r_tx : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_iicmb_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_iicmb_wb_regs
// Description : Self-checking bench for iicmb_wb_regs: vector table, directed
//               corner sequences and randomized traffic against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iicmb_wb_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0] adr = 2'd0;
    logic [7:0] wdat = 8'h00;
    logic       ack;
    logic [7:0] rdat;
    logic       irq;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [2:0] cmd_code;
    logic [7:0] cmd_data;
    logic       rsp_valid = 1'b0;
    logic [1:0] rsp_code = 2'd0;
    logic [7:0] rsp_data = 8'h00;
    logic       bus_busy = 1'b0, bus_captured = 1'b0;
    logic [3:0] bus_id = 4'd5;
    logic [7:0] fsm_state = 8'h3C;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iicmb_wb_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(wdat), .ack_o(ack), .dat_o(rdat), .irq(irq),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_code_o(cmd_code),
        .cmd_data_o(cmd_data), .rsp_valid_i(rsp_valid), .rsp_code_i(rsp_code),
        .rsp_data_i(rsp_data), .bus_busy_i(bus_busy), .bus_captured_i(bus_captured),
        .bus_id_i(bus_id), .fsm_state_i(fsm_state)
    );

    // Reference model: register contents and command lifecycle per access.
    bit       m_e, m_ie, m_don, m_nak, m_al, m_err, m_irq;
    bit       m_offered, m_accepted;
    bit [7:0] m_tx, m_rx;
    bit [2:0] m_last;

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_ie = 0; m_tx = 0; m_rx = 0; m_last = 0;
        m_don = 1; m_nak = 0; m_al = 0; m_err = 0; m_irq = 0;
        m_offered = 0; m_accepted = 0;
    endtask

    function automatic bit [7:0] model_value(bit [1:0] a);
        case (a)
            2'd0:    return {m_e, m_ie, bus_busy, bus_captured, bus_id};
            2'd1:    return m_rx;
            2'd2:    return {m_don, m_nak, m_al, m_err, 1'b0, m_last};
            default: return fsm_state;
        endcase
    endfunction

    task automatic model_write(bit [1:0] a, bit [7:0] d);
        case (a)
            2'd0: begin
                m_e = d[7]; m_ie = d[6];
                if (!m_ie) m_irq = 0;
                if (!m_e) begin m_offered = 0; m_accepted = 0; end
            end
            2'd1: m_tx = d;
            2'd2: if (m_e && !m_offered && !m_accepted) begin
                m_last = d[2:0];
                {m_don, m_nak, m_al, m_err} = 4'b0000;
                if (d[2:0] == 3'd7) begin
                    m_err = 1;
                    if (m_ie) m_irq = 1;
                end else begin
                    m_offered = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_rsp(bit [1:0] c, bit [7:0] d);
        if (m_accepted) begin
            case (c)
                2'd0: m_don = 1;
                2'd1: m_nak = 1;
                2'd2: m_al = 1;
                default: m_err = 1;
            endcase
            if (m_last == 3'd3 || m_last == 3'd4) m_rx = d;
            if (m_ie) m_irq = 1;
            m_accepted = 0;
        end
    endtask

    task automatic wb_access(input bit w, input bit [1:0] a, input bit [7:0] d,
                             output logic [7:0] rd);
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d;
        @(negedge clk);
        check1("ack", ack, 1'b1);
        rd = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wr(bit [1:0] a, bit [7:0] d);
        logic [7:0] dummy;
        wb_access(1'b1, a, d, dummy);
        model_write(a, d);
    endtask

    task automatic rd_chk(string name, bit [1:0] a, bit [7:0] exp);
        logic [7:0] v;
        wb_access(1'b0, a, 8'h00, v);
        check8(name, v, exp);
        if (a == 2'd2) m_irq = 0;
    endtask

    task automatic do_accept(int hold);
        for (int i = 0; i < hold; i++) begin
            check1("cmd_valid_hold", cmd_valid, 1'b1);
            check8("cmd_code_hold", {5'd0, cmd_code}, {5'd0, m_last});
            check8("cmd_data_hold", cmd_data, m_tx);
            @(negedge clk);
        end
        check1("cmd_valid_pre", cmd_valid, 1'b1);
        cmd_ready = 1;
        @(negedge clk);
        cmd_ready = 0;
        m_offered = 0; m_accepted = 1;
        check1("cmd_valid_drop", cmd_valid, 1'b0);
    endtask

    task automatic send_rsp(bit [1:0] c, bit [7:0] d);
        @(negedge clk);
        rsp_valid = 1; rsp_code = c; rsp_data = d;
        @(negedge clk);
        rsp_valid = 0;
        model_rsp(c, d);
        check1("irq_after_rsp", irq, m_irq);
    endtask

    typedef struct {
        bit       w;
        bit [1:0] a;
        bit [7:0] d;
        bit [7:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [7:0] v;
        bit   [7:0] dd;
        int         op;
        int         hold;

        tbl[0]  = '{1'b0, 2'd2, 8'h00, 8'h80};
        tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'h05};
        tbl[2]  = '{1'b0, 2'd1, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 2'd3, 8'h00, 8'h3C};
        tbl[4]  = '{1'b1, 2'd3, 8'hFF, 8'h00};
        tbl[5]  = '{1'b0, 2'd3, 8'h00, 8'h3C};
        tbl[6]  = '{1'b1, 2'd0, 8'h40, 8'h00};
        tbl[7]  = '{1'b0, 2'd0, 8'h00, 8'h45};
        tbl[8]  = '{1'b1, 2'd2, 8'h01, 8'h00};
        tbl[9]  = '{1'b0, 2'd2, 8'h00, 8'h80};
        tbl[10] = '{1'b1, 2'd1, 8'h5A, 8'h00};
        tbl[11] = '{1'b1, 2'd0, 8'hC0, 8'h00};
        tbl[12] = '{1'b0, 2'd0, 8'h00, 8'hC5};
        tbl[13] = '{1'b0, 2'd1, 8'h00, 8'h00};

        // Reset with an access pending: no ack and quiet outputs.
        model_reset();
        cyc = 1; stb = 1;
        repeat (3) begin
            @(negedge clk);
            check1("reset_ack", ack, 1'b0);
        end
        check8("reset_dat", rdat, 8'h00);
        check1("reset_irq", irq, 1'b0);
        check1("reset_valid", cmd_valid, 1'b0);
        check8("reset_cmd", {5'd0, cmd_code} | cmd_data, 8'h00);
        cyc = 0; stb = 0;
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].w) wr(tbl[i].a, tbl[i].d);
            else rd_chk($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
        end
        check1("tbl_no_cmd", cmd_valid, 1'b0);

        // Held strobe: ack on alternate cycles, dat_o zero outside ack.
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("held_ack", ack, (i % 2) == 0);
            check8("held_dat", rdat, ((i % 2) == 0) ? 8'h3C : 8'h00);
        end
        cyc = 0; stb = 0;

        // Write command with stalled ready, DON response, irq handling.
        wr(2'd0, 8'hC0);
        wr(2'd1, 8'h44);
        wr(2'd2, 8'h01);
        check8("issue_data", cmd_data, 8'h44);
        do_accept(3);
        send_rsp(2'd0, 8'h00);
        check1("irq_don", irq, 1'b1);
        rd_chk("cmdr_don", 2'd2, 8'h81);
        check1("irq_cleared", irq, 1'b0);

        // Read command loads rx; NAK response status.
        wr(2'd2, 8'h03);
        do_accept(0);
        send_rsp(2'd0, 8'hA5);
        rd_chk("dpr_rx", 2'd1, 8'hA5);
        rd_chk("cmdr_read", 2'd2, 8'h83);
        wr(2'd2, 8'h01);
        do_accept(1);
        send_rsp(2'd1, 8'h99);
        rd_chk("cmdr_nak", 2'd2, 8'h41);
        rd_chk("dpr_keep", 2'd1, 8'hA5);

        // Invalid command code.
        wr(2'd2, 8'h07);
        check1("bad_no_valid", cmd_valid, 1'b0);
        check1("bad_irq", irq, 1'b1);
        @(negedge clk);
        check1("bad_no_valid2", cmd_valid, 1'b0);
        rd_chk("cmdr_err", 2'd2, 8'h17);

        // CMDR write ignored while waiting for the response.
        wr(2'd2, 8'h04);
        do_accept(0);
        wr(2'd2, 8'h02);
        check1("busy_no_valid", cmd_valid, 1'b0);
        rd_chk("cmdr_busy", 2'd2, 8'h04);
        send_rsp(2'd2, 8'h3E);
        rd_chk("cmdr_al", 2'd2, 8'h24);
        rd_chk("dpr_nak_rx", 2'd1, 8'h3E);

        // Disable during ISSUE: command dropped, later response ignored.
        wr(2'd2, 8'h00);
        check1("issue_valid", cmd_valid, 1'b1);
        wr(2'd0, 8'h00);
        check1("disable_valid", cmd_valid, 1'b0);
        send_rsp(2'd0, 8'h00);
        check1("disable_irq", irq, 1'b0);
        rd_chk("cmdr_disabled", 2'd2, 8'h00);
        wr(2'd0, 8'hC0);

        // Response coinciding with a CMDR read: irq must stay set.
        wr(2'd2, 8'h02);
        do_accept(0);
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = 2'd2;
        rsp_valid = 1; rsp_code = 2'd0; rsp_data = 8'h11;
        @(negedge clk);
        check1("race_ack", ack, 1'b1);
        check8("race_dat", rdat, 8'h02);
        cyc = 0; stb = 0;
        @(negedge clk);
        rsp_valid = 0;
        m_irq = 0;
        model_rsp(2'd0, 8'h11);
        check1("race_irq", irq, 1'b1);
        rd_chk("cmdr_race", 2'd2, 8'h82);
        check1("race_irq_clr", irq, 1'b0);

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    dd = 8'($urandom);
                    dd[7] = ($urandom_range(0, 5) != 0);
                    wr(2'd0, dd);
                end
                1: wr(2'd1, 8'($urandom));
                2, 3: begin
                    dd[1:0] = 2'($urandom);
                    rd_chk("rand_read", dd[1:0], model_value(dd[1:0]));
                end
                4, 5, 6: begin
                    wr(2'd2, 8'($urandom));
                    if (m_offered) begin
                        hold = $urandom_range(0, 3);
                        if ($urandom_range(0, 7) == 0) begin
                            repeat (hold) @(negedge clk);
                            dd = 8'($urandom);
                            dd[7] = 0;
                            wr(2'd0, dd);
                            check1("rand_abort_valid", cmd_valid, 1'b0);
                        end else begin
                            do_accept(hold);
                            if ($urandom_range(0, 3) == 0) wr(2'd2, 8'($urandom));
                            if ($urandom_range(0, 9) == 0) begin
                                dd = 8'($urandom);
                                dd[7] = 0;
                                wr(2'd0, dd);
                            end
                            if ($urandom_range(0, 3) == 0) begin
                                dd[1:0] = 2'($urandom);
                                rd_chk("rand_wait_read", dd[1:0], model_value(dd[1:0]));
                            end
                            send_rsp(2'($urandom), 8'($urandom));
                        end
                    end
                end
                7: send_rsp(2'($urandom), 8'($urandom));
                8: begin
                    bus_busy = 1'($urandom);
                    bus_captured = 1'($urandom);
                    bus_id = 4'($urandom);
                    fsm_state = 8'($urandom);
                end
                default: wr(2'd3, 8'($urandom));
            endcase
            check1("rand_irq", irq, m_irq);
            check1("rand_valid", cmd_valid, m_offered);
        end

        // Reset in the middle of a command.
        wr(2'd0, 8'hC0);
        wr(2'd2, 8'h01);
        check1("pre_rst_valid", cmd_valid, 1'b1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check1("rst_valid", cmd_valid, 1'b0);
        check8("rst_cmd", {5'd0, cmd_code} | cmd_data, 8'h00);
        rst = 0;
        model_reset();
        rd_chk("rst_cmdr", 2'd2, 8'h80);
        rd_chk("rst_csr", 2'd0, {2'b00, bus_busy, bus_captured, bus_id});
        rd_chk("rst_dpr", 2'd1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
